// File: rtl/fifo_stream_reader.sv
// Consumer-side reader for the synchronous FIFO: issues rd_en under a credit rule
// and re-presents the 1-cycle-latency read data through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  proto_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] buf0;
    logic [FIFO_WIDTH-1:0] buf1;
    logic                  pop;
    logic [2:0]            credit;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign busy    = (state != IDLE);

    // Slots committed next cycle: buffered + in flight - leaving now; must stay below 2.
    assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (credit < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (enable) state <= RUN;
                RUN:  if (!enable) state <= STOP;
                STOP: begin
                    if (enable)
                        state <= RUN;
                    else if (!inflight && occ == 2'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        buf0 <= fifo_data_out;
                    else
                        buf1 <= fifo_data_out;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_data_out;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_read <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (pop)
                words_read <= words_read + CNT_WIDTH'(1);
            if (fifo_underflow)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model, expected-word queue and
// a cycle table for start latency, stall and stop/drain.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        busy;
    logic [15:0] words_read;
    logic        proto_err;

    fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .words_read(words_read), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // FIFO model: word at index i holds i+1; contents are [rd_ptr, wr_ptr)
    int          rd_ptr, wr_ptr;
    logic [15:0] exp_q[$];
    int          m_occ;
    logic        m_infl;
    int          cnt_m;
    logic        stall_prev;
    logic [15:0] prev_data;
    int          cyc;
    int          first_pop, last_pop;
    logic        s_rd, s_valid, s_busy;

    typedef struct {
        logic en, rdy, rd, valid, busy;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic        pop_s;
        logic [15:0] w;
        logic [15:0] got;
        @(negedge clk);
        pop_s   = m_valid && m_ready;
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_busy  = busy;
        if (fifo_empty) check(!fifo_rd_en, "rd_en_while_empty", fifo_rd_en, 0);
        if (stall_prev) begin
            check(m_valid, "valid_dropped_without_pop", m_valid, 1);
            check(m_data == prev_data, "data_stable_in_stall", m_data, prev_data);
        end
        if (pop_s) begin
            if (exp_q.size() == 0) begin
                check(0, "unexpected_word", m_data, 0);
            end else begin
                w   = exp_q.pop_front();
                got = m_data;
                check(got == w, "word_order", got, w);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #1;
        cyc++;
        if (m_infl && m_occ == 2) check(0, "push_into_full_skid", m_occ, 1);
        m_occ  = m_occ + int'(m_infl) - int'(pop_s);
        m_infl = s_rd;
        check(m_occ <= 2, "occupancy_le_2", m_occ, 2);
        check(m_valid == (m_occ != 0), "valid_vs_occupancy", m_valid, m_occ != 0);
        if (s_rd) begin
            fifo_data_out = 16'(rd_ptr + 1);
            exp_q.push_back(fifo_data_out);
            rd_ptr++;
        end
        if (pop_s) cnt_m++;
        check(words_read == 16'(cnt_m), "words_read", words_read, 16'(cnt_m));
        fifo_empty = (rd_ptr == wr_ptr);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        exp_q.delete();
        m_occ = 0; m_infl = 1'b0; cnt_m = 0; stall_prev = 1'b0;
        rd_ptr = 0; wr_ptr = 0;
        fifo_empty = 1'b1; fifo_data_out = '0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic restart(input int n);
        enable = 1'b0; m_ready = 1'b1; fifo_underflow = 1'b0;
        assert_reset();
        release_reset();
        wr_ptr = n;
        fifo_empty = (rd_ptr == wr_ptr);
        first_pop = -1; last_pop = -1; cyc = 0;
    endtask

    task automatic drain();
        int n;
        enable = 1'b0; m_ready = 1'b1;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        check(!busy, "drain_timeout", busy, 0);
        check(exp_q.size() == 0, "drain_all_delivered", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        enable = 1'b0; m_ready = 1'b1; fifo_underflow = 1'b0;
        assert_reset();
        check(m_valid == 0 && m_data == 0 && fifo_rd_en == 0 && busy == 0 &&
              words_read == 0 && proto_err == 0, "reset_state",
              {m_valid, fifo_rd_en, busy, proto_err}, 0);
        release_reset();

        // Cycle table: start latency, stall with full skid, stop and drain
        vecs[0]  = '{1, 1, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 0, 1};
        vecs[2]  = '{1, 1, 1, 0, 1};
        vecs[3]  = '{1, 0, 0, 1, 1};
        vecs[4]  = '{1, 0, 0, 1, 1};
        vecs[5]  = '{1, 1, 1, 1, 1};
        vecs[6]  = '{1, 1, 1, 1, 1};
        vecs[7]  = '{0, 1, 1, 1, 1};
        vecs[8]  = '{0, 1, 0, 1, 1};
        vecs[9]  = '{0, 1, 0, 1, 1};
        vecs[10] = '{0, 1, 0, 0, 1};
        vecs[11] = '{0, 1, 0, 0, 0};
        restart(8);
        for (int i = 0; i < 12; i++) begin
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            tick();
            check(s_rd == vecs[i].rd, $sformatf("vec%0d_rd_en", i), s_rd, vecs[i].rd);
            check(s_valid == vecs[i].valid, $sformatf("vec%0d_valid", i), s_valid, vecs[i].valid);
            check(s_busy == vecs[i].busy, $sformatf("vec%0d_busy", i), s_busy, vecs[i].busy);
        end
        check(cnt_m == 5, "vec_words_delivered", cnt_m, 5);
        check(wr_ptr - rd_ptr == 3, "vec_fifo_left", wr_ptr - rd_ptr, 3);

        // Full-rate streaming of 8 words
        restart(8);
        enable = 1'b1;
        n = 0;
        while (cnt_m < 8 && n < 40) begin
            tick();
            n++;
        end
        check(cnt_m == 8, "stream_count", cnt_m, 8);
        check(last_pop - first_pop == 7, "stream_consecutive", last_pop - first_pop, 7);
        check(words_read == 16'd8, "stream_words_read", words_read, 8);
        drain();

        // Back-pressure pattern 1,0,0 repeating
        restart(8);
        enable = 1'b1;
        n = 0;
        while (cnt_m < 8 && n < 80) begin
            m_ready = (n % 3 == 0);
            tick();
            n++;
        end
        check(cnt_m == 8, "bp_count", cnt_m, 8);
        drain();

        // Stop after exactly 3 reads are issued
        restart(8);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b0;
        drain();
        check(cnt_m == 3, "stop_delivered", cnt_m, 3);
        check(wr_ptr - rd_ptr == 5, "stop_fifo_retains", wr_ptr - rd_ptr, 5);
        check(dut.state == 2'd0, "stop_state_idle", dut.state, 0);

        // Sticky protocol error
        restart(0);
        tick();
        check(proto_err == 0, "proto_err_clear", proto_err, 0);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        check(proto_err == 1, "proto_err_set", proto_err, 1);
        for (int i = 0; i < 4; i++) tick();
        check(proto_err == 1, "proto_err_sticky", proto_err, 1);
        assert_reset();
        check(proto_err == 0, "proto_err_reset", proto_err, 0);
        release_reset();

        // Asynchronous reset mid-stream with a full skid buffer
        restart(8);
        enable = 1'b1;
        n = 0;
        while (cnt_m < 2 && n < 20) begin
            tick();
            n++;
        end
        m_ready = 1'b0;
        n = 0;
        while (m_occ < 2 && n < 10) begin
            tick();
            n++;
        end
        check(m_occ == 2 && m_valid, "midstream_full", m_occ, 2);
        #2;
        assert_reset();
        check(m_valid == 0, "async_rst_valid", m_valid, 0);
        check(m_data == 0, "async_rst_data", m_data, 0);
        check(fifo_rd_en == 0, "async_rst_rd_en", fifo_rd_en, 0);
        check(words_read == 0, "async_rst_words", words_read, 0);
        check(busy == 0, "async_rst_busy", busy, 0);
        release_reset();

        // Counter wrap at 2^16 pops
        restart(65540);
        enable = 1'b1;
        n = 0;
        while (cnt_m < 65535 && n < 70000) begin
            tick();
            n++;
        end
        check(words_read == 16'hFFFF, "wrap_preset", words_read, 16'hFFFF);
        n = 0;
        while (cnt_m < 65536 && n < 5) begin
            tick();
            n++;
        end
        check(words_read == 16'h0000, "wrap_to_zero", words_read, 0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
